// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Pulls words from a show-ahead FIFO read port and presents them as a
// valid/ready output stream. A two-entry in-order buffer decouples the FIFO
// pop from the consumer's ready. As a result, rpull never depends on m_ready,
// and the stream can still move one word per cycle.
//
// Optional feature: define FIFO_STREAM_READER_CNT_EN to add the word_cnt
// output. word_cnt counts delivered words, wraps at 2^CNT_WIDTH, and is
// cleared by reset and by flush.
//
// Parameters
//   DATA_WIDTH  width of FIFO words and output data
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports
//   clk       single clock, rising-edge
//   rst       asynchronous active-high reset
//   rempty    FIFO read-side empty flag
//   rpull     FIFO pop request; head consumed at the edge where rpull=1
//   rdata     FIFO head word (show-ahead, valid while rempty=0)
//   en        fetch enable
//   flush     discard request, sampled every cycle
//   m_valid   output stream valid
//   m_ready   output stream ready
//   m_data    output stream data
//   busy      FSM not idle or buffer holds words
//   word_cnt  delivered-word count (only with FIFO_STREAM_READER_CNT_EN)

module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rempty,
  output logic                  rpull,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic push;
  logic pop;

  // --------------------------------------------------------------------------
  // FSM next state. Flush takes priority over everything else. FLUSH keeps
  // draining the FIFO until it reports empty with flush released.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = RUN;
        end
        RUN: begin
          if (!en) state_d = IDLE;
        end
        FLUSH: begin
          if (rempty) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO side. In RUN, pull only while the buffer has room. In FLUSH, pull
  // unconditionally so that the pulled words are thrown away.
  // --------------------------------------------------------------------------
  assign rpull = ((state_q == RUN) && !rempty && (occ_q < 2'd2)) ||
                 ((state_q == FLUSH) && !rempty);

  // Only words pulled in RUN enter the buffer.
  assign push = (state_q == RUN) && rpull;

  // --------------------------------------------------------------------------
  // Stream side
  // --------------------------------------------------------------------------
  assign m_valid = (occ_q != 2'd0) && (state_q != FLUSH);
  assign m_data  = head_q;
  assign pop     = m_valid && m_ready;
  assign busy    = (state_q != IDLE) || (occ_q != 2'd0);

  // --------------------------------------------------------------------------
  // Buffer update. head_q is always the oldest word and tail_q is the
  // second-oldest. A flush empties the buffer at the edge where it is
  // sampled. Any push or transfer at that same edge is discarded.
  // --------------------------------------------------------------------------
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = rdata;
          end else begin
            tail_d = rdata;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            head_d = tail_q;
          end
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged. The new word goes behind whatever remains.
          if (occ_q == 2'd1) begin
            head_d = rdata;
          end else begin
            head_d = tail_q;
            tail_d = rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional delivered-word counter
  // --------------------------------------------------------------------------
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign word_cnt = cnt_q;
`else
  // CNT_WIDTH only shapes the optional counter.
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH == 0);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Drives fifo_stream_reader from a queue-based FIFO model. The bench uses
// directed scenarios first, then randomized en, flush, ready and refill
// traffic. It compares every cycle against a queue-level reference model.

module tb_fifo_stream_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          rempty;
  logic          rpull;
  logic [DW-1:0] rdata;
  logic          en;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [CW-1:0] word_cnt;
`endif

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rempty  (rempty),
    .rpull   (rpull),
    .rdata   (rdata),
    .en      (en),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {MIdle, MRun, MFlush} mode_e;

  mode_e         mode;
  logic [DW-1:0] fifo[$];   // external FIFO contents, head at index 0
  logic [DW-1:0] held[$];   // words the reader should be holding, oldest first
  int unsigned   delivered; // transfers since last reset/flush
  logic [DW-1:0] seen[$];   // words observed leaving the stream
  int            n_cmp;
  int            n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Call it at the negedge with the inputs already set.
  task automatic step();
    logic          empty;
    logic [DW-1:0] head;
    logic          e_rpull;
    logic          e_valid;
    logic          e_busy;
    logic          d_rpull;
    empty  = (fifo.size() == 0);
    head   = empty ? '0 : fifo[0];
    rempty = empty;
    rdata  = head;
    #1;
    e_valid = (held.size() != 0) && (mode != MFlush);
    e_rpull = !empty && ((mode == MRun && held.size() < 2) || mode == MFlush);
    e_busy  = (mode != MIdle) || (held.size() != 0);
    check_eq("rpull", 64'(rpull), 64'(e_rpull));
    check_eq("m_valid", 64'(m_valid), 64'(e_valid));
    check_eq("busy", 64'(busy), 64'(e_busy));
    if (e_valid) check_eq("m_data", 64'(m_data), 64'(held[0]));
`ifdef FIFO_STREAM_READER_CNT_EN
    check_eq("word_cnt", 64'(word_cnt), 64'(delivered % (1 << CW)));
`endif
    d_rpull = rpull;
    if (m_valid && m_ready) seen.push_back(m_data);
    @(posedge clk);
    if (flush) begin
      held.delete();
      delivered = 0;
    end else begin
      if (e_valid && m_ready) begin
        void'(held.pop_front());
        delivered++;
      end
      if (e_rpull && mode == MRun) held.push_back(head);
    end
    if (flush) mode = MFlush;
    else if (mode == MIdle && en) mode = MRun;
    else if (mode == MRun && !en) mode = MIdle;
    else if (mode == MFlush && empty) mode = MIdle;
    if (d_rpull && fifo.size() != 0) void'(fifo.pop_front());
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rpull"}, 64'(rpull), 64'd0);
    check_eq({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_m_data"}, 64'(m_data), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
    check_eq({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
`endif
  endtask

  // Asynchronous reset raised mid-cycle. Call it at the negedge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    held.delete();
    mode      = MIdle;
    delivered = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    mode      = MIdle;
    delivered = 0;
    rst       = 1'b1;
    en        = 1'b0;
    flush     = 1'b0;
    m_ready   = 1'b0;
    rempty    = 1'b1;
    rdata     = '0;
    #1 check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three words stream out back-to-back.
    fifo    = '{32'hA1, 32'hA2, 32'hA3};
    en      = 1'b1;
    m_ready = 1'b1;
    seen.delete();
    repeat (6) step();
    check_eq("seq3_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] w;
      w = (i < seen.size()) ? seen[i] : '0;
      check_eq("seq3_word", 64'(w), 64'(32'hA1 + i));
    end
    en = 1'b0;
    repeat (2) step();

    // Backpressure: only two words are pulled, and the head is held.
    fifo    = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    en      = 1'b1;
    m_ready = 1'b0;
    seen.delete();
    repeat (6) step();
    check_eq("bp_pulls", 64'(fifo.size()), 64'd2);
    check_eq("bp_head", 64'(m_data), 64'(32'hB1));
    check_eq("bp_valid", 64'(m_valid), 64'd1);
    check_eq("bp_rpull", 64'(rpull), 64'd0);

    // Release backpressure: order is preserved through the push/pop overlap.
    m_ready = 1'b1;
    repeat (6) step();
    check_eq("bp_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] w;
      w = (i < seen.size()) ? seen[i] : '0;
      check_eq("bp_order", 64'(w), 64'(32'hB1 + i));
    end

    // Flush with a full buffer and three words still waiting in the FIFO.
    fifo    = '{32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    m_ready = 1'b0;
    repeat (4) step();
    check_eq("fl_pre_fifo", 64'(fifo.size()), 64'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    en    = 1'b0;
    repeat (6) step();
    check_eq("fl_drained", 64'(fifo.size()), 64'd0);
    check_eq("fl_busy", 64'(busy), 64'd0);
    check_eq("fl_valid", 64'(m_valid), 64'd0);

    // Reset while a word is buffered, then resume with the next FIFO word.
    fifo    = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    en      = 1'b1;
    m_ready = 1'b1;
    repeat (3) step();
    pulse_reset();
    seen.delete();
    repeat (6) step();
    check_eq("rst_resume_first", 64'((seen.size() != 0) ? seen[0] : '0), 64'(32'hD3));

`ifdef FIFO_STREAM_READER_CNT_EN
    // Seventeen transfers on a 4-bit counter wrap to 1.
    flush = 1'b1;
    step();
    flush = 1'b0;
    en    = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 17; i++) fifo.push_back(32'h100 + i);
    en      = 1'b1;
    m_ready = 1'b1;
    repeat (24) step();
    check_eq("cnt_wrap", 64'(word_cnt), 64'd1);
`endif

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      flush   = ($urandom_range(0, 59) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0 && fifo.size() < 8) fifo.push_back($urandom());
      if ($urandom_range(0, 699) == 0) pulse_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
